// File: rtl/biquad8_coeff_pkg.sv
// Shared constants and FSM encoding for the biquad8 coefficient loader.
// CBITS_DEFAULT must match the B-port width used by the biquad stages.
package biquad8_coeff_pkg;

  localparam int CBITS_DEFAULT  = 18;
  localparam int NSAMP_DEFAULT  = 8;
  localparam int NCHAIN_DEFAULT = 2 * (NSAMP_DEFAULT - 2);

  // B1 cascade length for a stage processing nsamp samples per clock
  function automatic int calc_nchain(input int nsamp);
    return 2 * (nsamp - 2);
  endfunction

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_UPDATE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

endpackage

// File: rtl/biquad8_coeff_loader.sv
// Shadow-buffered coefficient writer for the biquad8 incremental stage:
// streams the buffer into the DSP B cascade, pulses update, holds bypass.
module biquad8_coeff_loader
  import biquad8_coeff_pkg::*;
#(
  parameter int NSAMP       = NSAMP_DEFAULT,
  parameter int NCHAIN      = calc_nchain(NSAMP),
  parameter int CBITS       = CBITS_DEFAULT,
  parameter int BYPASS_HOLD = 16,
  parameter int AW          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [CBITS-1:0] wr_dat_i,
  input  logic             commit_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [CBITS-1:0] coeff_dat_o,
  output logic             coeff_wr_o,
  output logic             coeff_update_o,
  output logic             bypass_o
);

  localparam int CW = $clog2(NCHAIN + 1);
  localparam int HW = (BYPASS_HOLD > 0) ? $clog2(BYPASS_HOLD + 1) : 1;

  localparam logic [CW-1:0] LAST_SHIFT = CW'(NCHAIN - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NCHAIN - 1);
  localparam logic [AW:0]   NCHAIN_LIM = (AW + 1)'(NCHAIN);
  localparam logic [HW-1:0] HOLD_LOAD  = (BYPASS_HOLD > 0) ? HW'(BYPASS_HOLD - 1) : '0;

  state_t           state_q, state_d;
  logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CBITS-1:0] coeff_dat_q, coeff_dat_d;
  logic             err_q, err_d;

  logic [CBITS-1:0] shadow_mem [2**AW];

  logic             busy;
  logic             wr_ok;
  logic             wr_drop;
  logic             commit_ok;
  logic             commit_drop;
  logic [AW-1:0]    rd_addr;

  assign busy        = (state_q != ST_IDLE);
  assign wr_ok       = wr_en_i && !busy && ({1'b0, wr_addr_i} < NCHAIN_LIM);
  assign wr_drop     = wr_en_i && !wr_ok;
  assign commit_ok   = commit_i && !busy;
  assign commit_drop = commit_i && busy;

  // Entries leave last-first so that shadow[0] ends up in the first DSP
  assign rd_addr = LAST_ADDR - AW'(shift_cnt_q);

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    coeff_dat_d = coeff_dat_q;
    err_d       = err_q;

    if (wr_drop || commit_drop) begin
      err_d = 1'b1;
    end else if (commit_ok) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (commit_i) begin
          state_d     = ST_SHIFT;
          shift_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        // Data register trails the wr strobe by one clock, matching the IIR input stage
        coeff_dat_d = shadow_mem[rd_addr];
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == LAST_SHIFT) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (BYPASS_HOLD == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      hold_cnt_q  <= '0;
      coeff_dat_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      coeff_dat_q <= coeff_dat_d;
      err_q       <= err_d;
    end
  end

  // Shadow contents survive reset; software owns them
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      shadow_mem[wr_addr_i] <= wr_dat_i;
    end
  end

  assign busy_o         = busy;
  assign bypass_o       = busy;
  assign err_o          = err_q;
  assign coeff_dat_o    = coeff_dat_q;
  assign coeff_wr_o     = (state_q == ST_SHIFT);
  assign coeff_update_o = (state_q == ST_UPDATE);

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader: default build plus a BYPASS_HOLD=0
// build, with a model of the IIR B cascade capturing the streamed coefficients.
module tb_biquad8_coeff_loader;

  localparam int NCHAIN = 12;
  localparam int CBITS  = 18;
  localparam int AW     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CBITS-1:0] wr_dat;
  logic             commit;
  logic             commit0;

  logic             busy, err, coeff_wr, coeff_update, bypass;
  logic [CBITS-1:0] coeff_dat;
  logic             busy0, err0, coeff_wr0, coeff_update0, bypass0;
  logic [CBITS-1:0] coeff_dat0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  biquad8_coeff_loader dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_dat_i(wr_dat),
    .commit_i(commit), .busy_o(busy), .err_o(err), .coeff_dat_o(coeff_dat),
    .coeff_wr_o(coeff_wr), .coeff_update_o(coeff_update), .bypass_o(bypass)
  );

  biquad8_coeff_loader #(.BYPASS_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_dat_i(wr_dat),
    .commit_i(commit0), .busy_o(busy0), .err_o(err0), .coeff_dat_o(coeff_dat0),
    .coeff_wr_o(coeff_wr0), .coeff_update_o(coeff_update0), .bypass_o(bypass0)
  );

  // IIR side: strobes registered once, data shifted in the cycle after wr, latched on update
  logic             model_wr_d1 = 1'b0;
  logic             model_upd_d1 = 1'b0;
  logic [CBITS-1:0] model_chain [NCHAIN];
  logic [CBITS-1:0] model_active [NCHAIN];

  always @(posedge clk) begin
    model_wr_d1  <= coeff_wr;
    model_upd_d1 <= coeff_update;
    if (model_wr_d1) begin
      for (int j = NCHAIN - 1; j > 0; j--) model_chain[j] <= model_chain[j-1];
      model_chain[0] <= coeff_dat;
    end
    if (model_upd_d1) begin
      for (int j = 0; j < NCHAIN; j++) model_active[j] <= model_chain[j];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] addr, input logic [CBITS-1:0] dat);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_dat  = dat;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load_pattern(input logic [CBITS-1:0] base);
    for (int i = 0; i < NCHAIN; i++) write_entry(AW'(i), base + CBITS'(i));
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_idle_timeout busy=%b want 0", tag, busy);
    end
  endtask

  task automatic check_chain(input string tag, input logic [CBITS-1:0] base);
    for (int j = 0; j < NCHAIN; j++) begin
      vectors++;
      if (model_active[j] !== base + CBITS'(j)) begin
        miscompares++;
        $display("[TB] FAIL %s_chain[%0d] got %h want %h", tag, j, model_active[j], base + CBITS'(j));
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({busy, bypass, coeff_wr, coeff_update, err} !== 5'b0 || coeff_dat !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got busy%b byp%b wr%b upd%b err%b dat%h want all 0",
               busy, bypass, coeff_wr, coeff_update, err, coeff_dat);
    end
    vectors++;
    if ({busy0, bypass0, coeff_wr0, coeff_update0, err0} !== 5'b0 || coeff_dat0 !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs0 got busy%b byp%b wr%b upd%b err%b dat%h want all 0",
               busy0, bypass0, coeff_wr0, coeff_update0, err0, coeff_dat0);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || coeff_wr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release got busy%b wr%b want 0 0", busy, coeff_wr);
    end
  endtask

  task automatic test_load();
    load_pattern(18'h100);
    commit_pulse();
    for (int k = 0; k < NCHAIN; k++) begin
      vectors++;
      if (coeff_wr !== 1'b1 || coeff_update !== 1'b0 || busy !== 1'b1 || bypass !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL load_shift k=%0d got wr%b upd%b busy%b byp%b want 1 0 1 1",
                 k, coeff_wr, coeff_update, busy, bypass);
      end
      if (k > 0) begin
        vectors++;
        if (coeff_dat !== CBITS'(18'h100 + NCHAIN - k)) begin
          miscompares++;
          $display("[TB] FAIL load_dat k=%0d got %h want %h", k, coeff_dat, 18'h100 + NCHAIN - k);
        end
      end
      tick();
    end
    vectors++;
    if (coeff_update !== 1'b1 || coeff_wr !== 1'b0 || coeff_dat !== 18'h100 || bypass !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL load_update got upd%b wr%b dat%h byp%b want 1 0 100 1",
               coeff_update, coeff_wr, coeff_dat, bypass);
    end
    tick();
    for (int h = 0; h < 16; h++) begin
      vectors++;
      if (busy !== 1'b1 || bypass !== 1'b1 || coeff_update !== 1'b0 || coeff_wr !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL load_hold h=%0d got busy%b byp%b upd%b wr%b want 1 1 0 0",
                 h, busy, bypass, coeff_update, coeff_wr);
      end
      tick();
    end
    vectors++;
    if (busy !== 1'b0 || bypass !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_done got busy%b byp%b err%b want 0 0 0", busy, bypass, err);
    end
    tick();
    check_chain("load", 18'h100);
  endtask

  task automatic test_commit_during_shift();
    load_pattern(18'h200);
    commit_pulse();
    repeat (3) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    vectors++;
    if (err !== 1'b1 || coeff_wr !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL shift_commit_err got err%b wr%b want 1 1", err, coeff_wr);
    end
    wait_idle("shift_commit");
    tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL shift_commit_sticky got err%b want 1", err);
    end
    check_chain("shift_commit", 18'h200);
    commit_pulse();
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL recommit_clear got err%b busy%b want 0 1", err, busy);
    end
    wait_idle("recommit");
  endtask

  task automatic test_write_errors();
    int n = 0;
    load_pattern(18'h300);
    commit_pulse();
    while (coeff_update !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (coeff_update !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_wait_update got upd%b want 1", coeff_update);
    end
    tick();
    write_entry(4'd5, 18'h3FF);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_write_err got err%b busy%b want 1 1", err, busy);
    end
    wait_idle("hold_write");
    commit_pulse();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_recommit_clear got err%b want 0", err);
    end
    wait_idle("hold_reload");
    tick();
    check_chain("hold_reload", 18'h300);
    write_entry(4'd12, 18'h3AA);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL addr12_err got err%b busy%b want 1 0", err, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    int wr_count = 0;
    int n = 0;
    load_pattern(18'h400);
    commit_pulse();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({busy, bypass, coeff_wr, coeff_update, err} !== 5'b0 || coeff_dat !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs got busy%b byp%b wr%b upd%b err%b dat%h want all 0",
               busy, bypass, coeff_wr, coeff_update, err, coeff_dat);
    end
    rst = 1'b0;
    tick();
    commit_pulse();
    while (busy === 1'b1 && n < 100) begin
      if (coeff_wr === 1'b1) wr_count++;
      tick();
      n++;
    end
    vectors++;
    if (wr_count != NCHAIN || n != 29) begin
      miscompares++;
      $display("[TB] FAIL midreset_reload got wr%0d busy%0d want %0d 29", wr_count, n, NCHAIN);
    end
    tick();
    check_chain("midreset", 18'h400);
  endtask

  task automatic test_hold_zero();
    commit0 = 1'b1;
    tick();
    commit0 = 1'b0;
    vectors++;
    if (coeff_wr0 !== 1'b1 || busy0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold0_start got wr%b busy%b want 1 1", coeff_wr0, busy0);
    end
    repeat (NCHAIN) tick();
    vectors++;
    if (coeff_update0 !== 1'b1 || busy0 !== 1'b1 || bypass0 !== 1'b1 || coeff_dat0 !== 18'h400) begin
      miscompares++;
      $display("[TB] FAIL hold0_update got upd%b busy%b byp%b dat%h want 1 1 1 400",
               coeff_update0, busy0, bypass0, coeff_dat0);
    end
    tick();
    vectors++;
    if (busy0 !== 1'b0 || bypass0 !== 1'b0 || coeff_update0 !== 1'b0 || coeff_wr0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold0_idle got busy%b byp%b upd%b wr%b want 0 0 0 0",
               busy0, bypass0, coeff_update0, coeff_wr0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_dat  = '0;
    commit  = 1'b0;
    commit0 = 1'b0;
    repeat (2) tick();
    $display("[TB] starting directed tests");
    test_reset();
    test_load();
    test_commit_during_shift();
    test_write_errors();
    test_reset_mid_load();
    test_hold_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
